// File: rtl/adder_bist.sv
// Exhaustive built-in self test for a WIDTH-bit adder.
// Sweeps every operand pair, counts mismatches, keeps the first failure.
module adder_bist #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic             Cout,
  input  logic [WIDTH-1:0] S,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [7:0]       ErrCount,
  output logic [WIDTH-1:0] FailA,
  output logic [WIDTH-1:0] FailB
);

  localparam int IW = 2 * WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [3:0]      cnt;
  logic [WIDTH:0]  sum;
  logic            mismatch;
  logic            last;

  assign sum      = {1'b0, A} + {1'b0, B};
  assign mismatch = ({Cout, S} != sum);
  assign last     = &idx;

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE,
      ST_DONE:  if (Start) state_nxt = ST_DRIVE;
      ST_DRIVE: state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == 4'd1) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = last ? ST_DONE : ST_DRIVE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    unique case (state)
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK: Busy = 1'b1;
      ST_DONE:  Done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      A        <= '0;
      B        <= '0;
      idx      <= '0;
      cnt      <= '0;
      ErrCount <= '0;
      FailA    <= '0;
      FailB    <= '0;
      Pass     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE,
        ST_DONE: begin
          if (Start) begin
            idx      <= '0;
            ErrCount <= '0;
            FailA    <= '0;
            FailB    <= '0;
            Pass     <= 1'b0;
          end
        end
        ST_DRIVE: begin
          A   <= idx[IW-1:WIDTH];
          B   <= idx[WIDTH-1:0];
          cnt <= 4'(SETTLE);
        end
        ST_WAIT: cnt <= cnt - 4'd1;
        ST_CHECK: begin
          if (mismatch) begin
            if (ErrCount != 8'hff)
              ErrCount <= ErrCount + 8'd1;
            // Count never wraps, so zero means no earlier failure.
            if (ErrCount == 8'd0) begin
              FailA <= A;
              FailB <= B;
            end
          end
          if (last)
            Pass <= (ErrCount == 8'd0) && !mismatch;
          else
            idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist: good, stuck and inverted adders,
// restart, reset mid-pass and counter saturation.
module tb_adder_bist;

  logic       Clk;
  logic       rst;
  logic       start1;
  logic       start4;
  int         mode;
  int         tests;
  int         fails;
  int         n;
  int         bc;

  logic       a1, b1, cout1, s1;
  logic       busy1, done1, pass1;
  logic [7:0] err1;
  logic       fa1, fb1;
  logic [1:0] sm1;

  logic [3:0] a4, b4, s4, fa4, fb4;
  logic       cout4, busy4, done4, pass4;
  logic [7:0] err4;

  adder_bist #(.WIDTH(1), .SETTLE(1)) dut1 (
    .Clk(Clk), .Rst(rst), .Start(start1),
    .A(a1), .B(b1), .Cout(cout1), .S(s1),
    .Busy(busy1), .Done(done1), .Pass(pass1),
    .ErrCount(err1), .FailA(fa1), .FailB(fb1)
  );

  adder_bist #(.WIDTH(4), .SETTLE(3)) dut4 (
    .Clk(Clk), .Rst(rst), .Start(start4),
    .A(a4), .B(b4), .Cout(cout4), .S(s4),
    .Busy(busy4), .Done(done4), .Pass(pass4),
    .ErrCount(err4), .FailA(fa4), .FailB(fb4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // mode 0 good, 1 carry stuck low, 2 sum bit inverted
  always_comb begin
    sm1   = {1'b0, a1} + {1'b0, b1};
    cout1 = sm1[1];
    s1    = sm1[0];
    if (mode == 1) cout1 = 1'b0;
    if (mode == 2) s1 = ~sm1[0];
  end

  always_comb {cout4, s4} = ~({1'b0, a4} + {1'b0, b4});

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n = edge index at which Done is first seen (start edge is 1)
  task automatic run1(input int inj, output int nn, output int bb);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    nn = 1;
    bb = busy1 ? 1 : 0;
    while (!done1 && nn < 200) begin
      if (nn == inj) start1 = 1'b1;
      tick;
      start1 = 1'b0;
      nn++;
      if (busy1) bb++;
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    mode   = 0;
    rst    = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;

    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_err",  32'(err1),  32'd0);
    chk("rst_ab",   32'({a1, b1}), 32'd0);
    chk("rst_fail", 32'({fa1, fb1}), 32'd0);

    run1(0, n, bc);
    chk("good_lat",  32'(n),  32'd13);
    chk("good_busy", 32'(bc), 32'd12);
    chk("good_pass", 32'(pass1), 32'd1);
    chk("good_err",  32'(err1),  32'd0);
    chk("good_fail", 32'({fa1, fb1}), 32'd0);
    chk("good_hold", 32'({a1, b1}), 32'd3);
    tick;
    tick;
    chk("done_hold", 32'(done1), 32'd1);

    mode = 1;
    run1(0, n, bc);
    chk("stuck_done", 32'(done1), 32'd1);
    chk("stuck_pass", 32'(pass1), 32'd0);
    chk("stuck_err",  32'(err1),  32'd1);
    chk("stuck_fa",   32'(fa1),   32'd1);
    chk("stuck_fb",   32'(fb1),   32'd1);

    mode = 2;
    run1(0, n, bc);
    chk("inv_err",  32'(err1), 32'd4);
    chk("inv_fail", 32'({fa1, fb1}), 32'd0);
    chk("inv_pass", 32'(pass1), 32'd0);

    mode = 0;
    run1(5, n, bc);
    chk("busy_start_lat",  32'(n), 32'd13);
    chk("busy_start_pass", 32'(pass1), 32'd1);
    chk("busy_start_err",  32'(err1),  32'd0);

    mode = 2;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    tick;
    tick;
    chk("mid_busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_busy", 32'(busy1), 32'd0);
    chk("mrst_done", 32'(done1), 32'd0);
    chk("mrst_err",  32'(err1),  32'd0);
    chk("mrst_ab",   32'({a1, b1}), 32'd0);
    tick;
    chk("mrst_idle", 32'(busy1), 32'd0);

    rst    = 1'b1;
    start1 = 1'b1;
    tick;
    rst    = 1'b0;
    start1 = 1'b0;
    tick;
    chk("rst_prio", 32'(busy1), 32'd0);

    mode = 0;
    run1(0, n, bc);
    chk("after_lat",  32'(n), 32'd13);
    chk("after_pass", 32'(pass1), 32'd1);
    chk("after_err",  32'(err1),  32'd0);

    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 3000) begin
      tick;
      n++;
    end
    chk("sat_lat",  32'(n), 32'd1281);
    chk("sat_err",  32'(err4), 32'd255);
    chk("sat_pass", 32'(pass4), 32'd0);
    chk("sat_fail", 32'({fa4, fb4}), 32'd0);
    chk("sat_hold", 32'({a4, b4}), 32'hff);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
